lfsr_engine: RTL and testbench

LFSR_ENGINE -- requirements
Module: lfsr_engine

---
 rtl/lfsr_engine.sv | 150 +++++++++++++++
 tb/tb_lfsr_engine.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/lfsr_engine.sv
// Configurable Galois/Fibonacci LFSR with run/step control and a step-rate divider.
// Define LFSR_PERIOD_COUNT_EN to build the sequence-period measurement counter.
module lfsr_engine #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned DIV_BITS = 10
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [WIDTH-1:0] cfg_data,
  input  logic             mode,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  output logic [WIDTH-1:0] state_o,
  output logic             bit_o,
  output logic             tick_o,
  output logic             running_o,
  output logic             lockup_o,
  output logic [WIDTH-1:0] period_o,
  output logic             period_valid_o
);

  typedef enum logic [1:0] {StIdle, StRun, StStep} fsm_e;

  fsm_e                fsm_q, fsm_d;
  logic [WIDTH-1:0]    state_q, state_d, adv_state;
  logic [WIDTH-1:0]    taps_q, seed_q;
  logic [DIV_BITS-1:0] div_q, cnt_q, cnt_d, cfg_div;
  logic                tick_q, lockup_q;
  logic                taps_wr, seed_wr, div_wr;
  logic                adv;

  assign taps_wr = cfg_we && (cfg_sel == 2'd0);
  assign seed_wr = cfg_we && (cfg_sel == 2'd1);
  assign div_wr  = cfg_we && (cfg_sel == 2'd2);

  if (DIV_BITS > WIDTH) begin : g_div_ext
    assign cfg_div = {{(DIV_BITS - WIDTH){1'b0}}, cfg_data};
  end else begin : g_div_trunc
    assign cfg_div = cfg_data[DIV_BITS-1:0];
  end

  // Configuration writes never influence the run-control FSM.
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      StIdle: begin
        if (start)     fsm_d = StRun;
        else if (step) fsm_d = StStep;
      end
      StRun:   if (stop) fsm_d = StIdle;
      StStep:  fsm_d = StIdle;
      default: fsm_d = StIdle;
    endcase
  end

  // A seed load in the same cycle swallows the advance.
  always_comb begin
    adv = 1'b0;
    if (fsm_q == StStep)                         adv = 1'b1;
    else if (fsm_q == StRun && cnt_q == div_q)   adv = 1'b1;
    if (seed_wr)                                 adv = 1'b0;
  end

  always_comb begin
    adv_state = '0;
    if (state_q == '0) begin
      adv_state = WIDTH'(1);
    end else if (mode) begin
      adv_state = {^(state_q & taps_q), state_q[WIDTH-1:1]};
    end else if (state_q[0]) begin
      adv_state = (state_q >> 1) ^ taps_q;
    end else begin
      adv_state = state_q >> 1;
    end
  end

  always_comb begin
    state_d = state_q;
    if (seed_wr)  state_d = cfg_data;
    else if (adv) state_d = adv_state;
  end

  always_comb begin
    cnt_d = '0;
    if (fsm_q == StRun && !seed_wr && !div_wr && cnt_q != div_q) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      fsm_q    <= StIdle;
      state_q  <= WIDTH'(1);
      taps_q   <= '0;
      seed_q   <= WIDTH'(1);
      div_q    <= '0;
      cnt_q    <= '0;
      tick_q   <= 1'b0;
      lockup_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tick_q  <= adv;
      if (taps_wr) taps_q <= cfg_data;
      if (seed_wr) seed_q <= cfg_data;
      if (div_wr)  div_q  <= cfg_div;
      if (seed_wr)                       lockup_q <= 1'b0;
      else if (adv && state_q == '0)     lockup_q <= 1'b1;
    end
  end

`ifdef LFSR_PERIOD_COUNT_EN
  logic [WIDTH-1:0] pcnt_q, period_q;
  logic             pvalid_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pcnt_q   <= '0;
      period_q <= '0;
      pvalid_q <= 1'b0;
    end else if (seed_wr) begin
      pcnt_q   <= '0;
      pvalid_q <= 1'b0;
    end else if (adv) begin
      if (adv_state == seed_q) begin
        period_q <= pcnt_q + 1'b1;
        pvalid_q <= 1'b1;
        pcnt_q   <= '0;
      end else begin
        pcnt_q   <= pcnt_q + 1'b1;
      end
    end
  end

  assign period_o       = period_q;
  assign period_valid_o = pvalid_q;
`else
  assign period_o       = '0;
  assign period_valid_o = 1'b0;
`endif

  assign state_o   = state_q;
  assign bit_o     = state_q[0];
  assign tick_o    = tick_q;
  assign running_o = (fsm_q == StRun);
  assign lockup_o  = lockup_q;

endmodule

// File: tb/tb_lfsr_engine.sv
// Directed bench for lfsr_engine: a WIDTH=5 Galois instance and a WIDTH=4 Fibonacci instance.
module tb_lfsr_engine;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;

  logic       cfg_we5 = 1'b0, mode5 = 1'b0, start5 = 1'b0, stop5 = 1'b0, step5 = 1'b0;
  logic [1:0] cfg_sel5 = '0;
  logic [4:0] cfg_data5 = '0;
  logic [4:0] state5, period5;
  logic       bit5, tick5, running5, lockup5, pvalid5;

  logic       cfg_we4 = 1'b0, mode4 = 1'b1, start4 = 1'b0, stop4 = 1'b0, step4 = 1'b0;
  logic [1:0] cfg_sel4 = '0;
  logic [3:0] cfg_data4 = '0;
  logic [3:0] state4, period4;
  logic       bit4, tick4, running4, lockup4, pvalid4;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  lfsr_engine #(.WIDTH(5), .DIV_BITS(10)) u_dut5 (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we5), .cfg_sel(cfg_sel5), .cfg_data(cfg_data5),
    .mode(mode5), .start(start5), .stop(stop5), .step(step5), .state_o(state5), .bit_o(bit5),
    .tick_o(tick5), .running_o(running5), .lockup_o(lockup5), .period_o(period5),
    .period_valid_o(pvalid5)
  );

  lfsr_engine #(.WIDTH(4), .DIV_BITS(10)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .cfg_we(cfg_we4), .cfg_sel(cfg_sel4), .cfg_data(cfg_data4),
    .mode(mode4), .start(start4), .stop(stop4), .step(step4), .state_o(state4), .bit_o(bit4),
    .tick_o(tick4), .running_o(running4), .lockup_o(lockup4), .period_o(period4),
    .period_valid_o(pvalid4)
  );

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg5(input logic [1:0] sel, input logic [4:0] data);
    cfg_we5 = 1'b1; cfg_sel5 = sel; cfg_data5 = data;
    cyc();
    cfg_we5 = 1'b0;
  endtask

  task automatic cfg4(input logic [1:0] sel, input logic [3:0] data);
    cfg_we4 = 1'b1; cfg_sel4 = sel; cfg_data4 = data;
    cyc();
    cfg_we4 = 1'b0;
  endtask

  initial begin
    logic [4:0]  first [3];
    logic [15:0] tick_seen;
    int          ticks;
    bit          back_to_one;

    cyc(); cyc();
    reset_n = 1'b1;

    // Reset state
    check_val("rst_state", state5, 5'd1);
    check_val("rst_bit", bit5, 1'b1);
    check_val("rst_flags", {tick5, running5, lockup5, pvalid5}, 4'b0000);
    check_val("rst_period", period5, 5'd0);

    // Galois, taps 0x14, seed 1, div 0: full 31-state cycle
    mode5 = 1'b0;
    cfg5(2'd0, 5'h14);
    cfg5(2'd1, 5'h01);
    cfg5(2'd2, 5'h00);
    start5 = 1'b1; cyc(); start5 = 1'b0;
    check_val("run_enter", running5, 1'b1);
    ticks = 0;
    back_to_one = 1'b0;
    for (int i = 0; i < 40 && !back_to_one; i++) begin
      cyc();
      if (tick5) ticks++;
      if (i < 3) first[i] = state5;
      if (state5 == 5'd1) back_to_one = 1'b1;
    end
    check_val("gal_s1", first[0], 5'h14);
    check_val("gal_s2", first[1], 5'h0A);
    check_val("gal_s3", first[2], 5'h05);
    check_val("gal_return", back_to_one, 1'b1);
    check_val("gal_ticks", ticks, 31);
`ifdef LFSR_PERIOD_COUNT_EN
    check_val("gal_period", period5, 5'd31);
    check_val("gal_pvalid", pvalid5, 1'b1);
`else
    check_val("gal_period", period5, 5'd0);
    check_val("gal_pvalid", pvalid5, 1'b0);
`endif
    stop5 = 1'b1; cyc(); stop5 = 1'b0;
    check_val("stop_run", running5, 1'b0);
    cyc();
    check_val("stop_notick", tick5, 1'b0);

    // Divider 3: one tick every fourth RUN cycle, then stop+start -> IDLE
    cfg5(2'd2, 5'd3);
    start5 = 1'b1; cyc(); start5 = 1'b0;
    tick_seen = '0;
    for (int i = 0; i < 16; i++) begin
      cyc();
      tick_seen[i] = tick5;
    end
    check_val("div3_ticks", tick_seen, 16'b1000_1000_1000_1000);
    stop5 = 1'b1; start5 = 1'b1; cyc(); stop5 = 1'b0; start5 = 1'b0;
    check_val("stopstart_run", running5, 1'b0);
    ticks = 0;
    for (int i = 0; i < 8; i++) begin
      cyc();
      if (tick5) ticks++;
    end
    check_val("stopstart_ticks", ticks, 0);

    // Lock-up recovery from all-zero seed
    cfg5(2'd1, 5'h00);
    check_val("zero_seed", state5, 5'h00);
    step5 = 1'b1; cyc(); step5 = 1'b0;
    cyc();
    check_val("lock_state", state5, 5'h01);
    check_val("lock_flag", lockup5, 1'b1);
    check_val("lock_tick", tick5, 1'b1);
    cfg5(2'd1, 5'h03);
    check_val("lock_clr", lockup5, 1'b0);
    check_val("lock_seed", state5, 5'h03);

    // Reset in the middle of RUN with lockup set and state != 1
    cfg5(2'd1, 5'h00);
    step5 = 1'b1; cyc(); step5 = 1'b0;
    cyc();
    cfg5(2'd2, 5'd0);
    start5 = 1'b1; cyc(); start5 = 1'b0;
    cyc(); cyc();
    check_val("pre_rst_state", state5, 5'h0A);
    check_val("pre_rst_flags", {running5, lockup5}, 2'b11);
    reset_n = 1'b0; cyc(); reset_n = 1'b1;
    check_val("midrun_state", state5, 5'h01);
    check_val("midrun_flags", {tick5, running5, lockup5, pvalid5}, 4'b0000);
    check_val("midrun_period", period5, 5'd0);

    // Seed write coincident with an advance drops that advance
    cfg5(2'd0, 5'h14);
    start5 = 1'b1; cyc(); start5 = 1'b0;
    cyc();
    check_val("pre_seed_state", state5, 5'h14);
    cfg5(2'd1, 5'h09);
    check_val("seedcoin_state", state5, 5'h09);
    check_val("seedcoin_tick", tick5, 1'b0);
    check_val("seedcoin_pvalid", pvalid5, 1'b0);
    cyc();
    check_val("seedcoin_next", state5, 5'h10);
    check_val("seedcoin_tick2", tick5, 1'b1);
    stop5 = 1'b1; cyc(); stop5 = 1'b0;

    // Fibonacci WIDTH=4, taps 0011, seed 0001, two single steps
    mode4 = 1'b1;
    cfg4(2'd0, 4'b0011);
    cfg4(2'd1, 4'b0001);
    step4 = 1'b1; cyc(); step4 = 1'b0;
    check_val("fib_step_pre", {tick4, state4}, 5'b0_0001);
    cyc();
    check_val("fib_step1", state4, 4'b1000);
    check_val("fib_tick1", tick4, 1'b1);
    cyc();
    check_val("fib_idle_tick", tick4, 1'b0);
    step4 = 1'b1; cyc(); step4 = 1'b0;
    cyc();
    check_val("fib_step2", state4, 4'b0100);
    check_val("fib_tick2", tick4, 1'b1);
    check_val("fib_bit", bit4, 1'b0);
    cyc();
    check_val("fib_state_hold", {tick4, state4}, 5'b0_0100);

    // start beats step from IDLE
    start4 = 1'b1; step4 = 1'b1; cyc(); start4 = 1'b0; step4 = 1'b0;
    check_val("start_wins", running4, 1'b1);
    stop4 = 1'b1; cyc(); stop4 = 1'b0;
    check_val("fib_stop", running4, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
